conv3x3_relu_stage: RTL and testbench
=====================================

// Module: conv3x3_relu_stage
// PURPOSE
//  Consumes the 72-bit 3x3 window stream from the line-buffer window generator.
//  Applies a programmable signed 3x3 kernel plus bias, then an arithmetic right shift.
//  Applies ReLU and saturates the result to an 8-bit pixel.
//  Feeds the next CNN feature-map stage (pooling / output DMA).
//  Fully pipelined: one window accepted per cycle, no backpressure.
// PARAMETERS
//  OUT_W    510  valid windows per image line (IMG_W-2, IMG_W=512)
//  SHIFT    4    arithmetic right shift applied after bias add (0..15)
//  COEF_W   8    signed kernel coefficient width
//  BIAS_W   16   signed bias width
//  ACC_W    22   signed accumulator width
// PORTS
//  i_clk           in   1   clock, all logic on rising edge
//  i_rst_n         in   1   synchronous reset, active-low
//  i_win_data      in   72  window; pixel p[k]=i_win_data[8k+:8], k=0..8, unsigned
//  i_win_valid     in   1   window qualifier, may deassert at any cycle (gaps allowed)
//  i_coef_we       in   1   coefficient write strobe
//  i_coef_addr     in   4   0..8 -> kernel w[k]; 9 -> bias; 10..15 reserved
//  i_coef_data     in   16  write data; w[k] uses [COEF_W-1:0], bias uses all 16
//  o_pixel         out  8   result pixel
//  o_pixel_valid   out  1   o_pixel qualifier
//  o_line_done     out  1   1-cycle pulse with OUT_W-th valid output of a line
//  o_coef_err      out  1   1-cycle pulse: write rejected (busy or reserved addr)
//  o_busy          out  1   high while in RUN or while the pipeline holds valid data
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge):
//   - All outputs drive 0.
//   - w[0..8]=0, bias=0, state=IDLE, column count=0.
//   - Pipeline valid bits are cleared. In-flight windows are dropped, never emitted.
//  Arithmetic, per window:
//   - prod[k]  = $signed({1'b0,p[k]}) * w[k], 17b signed.
//   - sum      = sum(prod[0..8]) + sext(bias), ACC_W signed; no overflow possible.
//   - s        = sum >>> SHIFT (floor toward -inf).
//   - o_pixel  = (s<0) ? 0 : (s>255) ? 255 : s[7:0].
//  Pipeline: 4 stages, latency exactly 4 cycles from i_win_valid to o_pixel_valid.
//   - S1: 9 products.
//   - S2: three row sums (k=0-2, 3-5, 6-8).
//   - S3: total + bias.
//   - S4: shift, ReLU, saturate.
//   - Valid travels with data. Gaps at the input reproduce as gaps at the output.
//  FSM, states IDLE and RUN:
//   - IDLE->RUN on i_win_valid.
//   - RUN: col increments on each output valid.
//   - On the output valid with col==OUT_W-1: pulse o_line_done, set col=0, go to IDLE.
//   - A new window arriving in the same cycle as that pulse is accepted normally.
//     The FSM re-enters RUN on the next cycle, because the pipeline is
//     independent of the FSM state.
//   - o_busy = (state==RUN) | any pipeline valid bit.
//  Coefficient writes:
//   - Accepted only when o_busy=0 and addr<=9; the new value is used from the next cycle.
//   - A write while o_busy=1, or to addr 10..15: register unchanged, o_coef_err=1 next cycle.
//   - Coefficients are therefore constant across every window of a line.
//  i_win_valid and i_coef_we in the same cycle with o_busy=0: the write is rejected
//   (err pulse) and the window is processed with the old coefficients.
// STRUCTURE
//  Package conv_pkg:
//   - Typedefs coef_t (signed [COEF_W-1:0]), bias_t, acc_t.
//   - Constants OUT_W, COEF_ADDR_BIAS=9, PIX_MAX=255.
//  Sub-module conv3x3_mac_pipe: the S1-S4 datapath with its valid shift register.
//  This top level holds the coefficient registers, the FSM/column counter and error logic.
// TESTING
//  1. Reset, then w[4]=16, others 0, bias=0, SHIFT=4; window with p[4]=200
//     -> o_pixel=200, valid exactly 4 cycles after the input.
//  2. All w=1, bias=0; all p=255 -> s=2295>>4=143 -> o_pixel=143.
//  3. w[0]=-128, p[0]=255, others 0 -> negative sum -> o_pixel=0 (ReLU).
//     Then bias=32767 -> 2047 -> o_pixel=255 (saturate).
//  4. 510 windows with random valid gaps -> 510 outputs, order preserved.
//     Single o_line_done pulse aligned with the 510th output.
//     Back-to-back second line -> second pulse.
//  5. Coefficient write mid-line -> o_coef_err pulse, outputs unchanged.
//     Write to addr 12 while idle -> err pulse.
//  6. Assert i_rst_n=0 with 3 windows in flight -> no o_pixel_valid after reset.
//     Coefficients read back as 0 and the output pixel for any window is 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, types and constants for the 3x3 convolution + ReLU stage.
package conv_pkg;
    localparam int COEF_W         = 8;
    localparam int BIAS_W         = 16;
    localparam int ACC_W          = 22;
    localparam int PROD_W         = 17;
    localparam int NUM_TAPS       = 9;
    localparam int STAGES         = 4;
    localparam int OUT_W          = 510;
    localparam int COL_W          = $clog2(OUT_W);
    localparam int COEF_ADDR_BIAS = 9;
    localparam int PIX_MAX        = 255;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [BIAS_W-1:0] bias_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/conv3x3_mac_pipe.sv
// Four-stage datapath: products, row sums, total + bias, shift/ReLU/saturate.
module conv3x3_mac_pipe
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [71:0]                i_win_data,
    input  logic                       i_win_valid,
    input  logic [NUM_TAPS*COEF_W-1:0] i_coef,
    input  logic [BIAS_W-1:0]          i_bias,
    output logic [7:0]                 o_pixel,
    output logic                       o_pixel_valid,
    output logic                       o_any_valid
);
    logic [NUM_TAPS-1:0][PROD_W-1:0] prod_d, prod_q;
    logic [2:0][ACC_W-1:0]           row_d, row_q;
    acc_t                            tot_d, tot_q;
    logic [7:0]                      pix_d, pix_q;
    logic [STAGES:1]                 vld_d, vld_q;
    acc_t                            shifted;

    always_comb begin
        prod_d = '0;
        row_d  = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            // Pixels are unsigned: zero-extend before the signed multiply.
            prod_d[k] = PROD_W'($signed({1'b0, i_win_data[8*k +: 8]}))
                      * PROD_W'($signed(i_coef[COEF_W*k +: COEF_W]));
        end
        for (int r = 0; r < 3; r++) begin
            row_d[r] = ACC_W'($signed(prod_q[3*r]))
                     + ACC_W'($signed(prod_q[3*r+1]))
                     + ACC_W'($signed(prod_q[3*r+2]));
        end
        tot_d   = row_q[0] + row_q[1] + row_q[2] + ACC_W'($signed(i_bias));
        shifted = tot_q >>> SHIFT;
        if (shifted[ACC_W-1])
            pix_d = 8'h00;
        else if (shifted > acc_t'(PIX_MAX))
            pix_d = 8'hFF;
        else
            pix_d = shifted[7:0];
        vld_d = {vld_q[STAGES-1:1], i_win_valid};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prod_q <= '0;
            row_q  <= '0;
            tot_q  <= '0;
            pix_q  <= '0;
            vld_q  <= '0;
        end else begin
            prod_q <= prod_d;
            row_q  <= row_d;
            tot_q  <= tot_d;
            pix_q  <= pix_d;
            vld_q  <= vld_d;
        end
    end

    assign o_pixel       = pix_q;
    assign o_pixel_valid = vld_q[STAGES];
    assign o_any_valid   = |vld_q;
endmodule

// File: rtl/conv3x3_relu_stage.sv
// 3x3 conv + bias + shift + ReLU stage: coefficient registers, line FSM and
// write-error reporting around the MAC pipeline.
module conv3x3_relu_stage
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [71:0] i_win_data,
    input  logic        i_win_valid,
    input  logic        i_coef_we,
    input  logic [3:0]  i_coef_addr,
    input  logic [15:0] i_coef_data,
    output logic [7:0]  o_pixel,
    output logic        o_pixel_valid,
    output logic        o_line_done,
    output logic        o_coef_err,
    output logic        o_busy
);
    logic [NUM_TAPS*COEF_W-1:0] coef_d, coef_q;
    logic [BIAS_W-1:0]          bias_d, bias_q;
    state_t                     state_d, state_q;
    logic [COL_W-1:0]           col_d, col_q;
    logic                       err_d, err_q;
    logic                       any_vld, wr_ok, line_done;

    conv3x3_mac_pipe #(.SHIFT(SHIFT)) u_pipe (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_win_data    (i_win_data),
        .i_win_valid   (i_win_valid),
        .i_coef        (coef_q),
        .i_bias        (bias_q),
        .o_pixel       (o_pixel),
        .o_pixel_valid (o_pixel_valid),
        .o_any_valid   (any_vld)
    );

    assign o_busy    = (state_q == ST_RUN) | any_vld;
    assign line_done = o_pixel_valid && (col_q == COL_W'(OUT_W-1));

    always_comb begin
        coef_d  = coef_q;
        bias_d  = bias_q;
        state_d = state_q;
        col_d   = col_q;
        // A window in the same cycle blocks the write so a line never mixes coefficient sets.
        wr_ok   = i_coef_we && !o_busy && !i_win_valid && (i_coef_addr <= 4'(COEF_ADDR_BIAS));
        err_d   = i_coef_we && !wr_ok;
        if (wr_ok) begin
            if (i_coef_addr == 4'(COEF_ADDR_BIAS))
                bias_d = i_coef_data;
            for (int k = 0; k < NUM_TAPS; k++)
                if (i_coef_addr == 4'(k))
                    coef_d[COEF_W*k +: COEF_W] = i_coef_data[COEF_W-1:0];
        end
        if (o_pixel_valid)
            col_d = line_done ? '0 : col_q + COL_W'(1);
        case (state_q)
            // Windows still in flight after a line end resume RUN straight away.
            ST_IDLE: if (i_win_valid || any_vld) state_d = ST_RUN;
            ST_RUN:  if (line_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            coef_q  <= '0;
            bias_q  <= '0;
            state_q <= ST_IDLE;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            coef_q  <= coef_d;
            bias_q  <= bias_d;
            state_q <= state_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    assign o_line_done = line_done;
    assign o_coef_err  = err_q;
endmodule

// File: tb/tb_conv3x3_relu_stage.sv
// Scoreboard bench: stimulus pushes expected pixels/err pulses, a monitor pops and compares.
module tb_conv3x3_relu_stage;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [71:0] win_data = '0;
    logic        win_valid = 1'b0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic [7:0]  o_pixel;
    logic        o_pixel_valid, o_line_done, o_coef_err, o_busy;

    typedef struct {
        logic [7:0] pix;
        logic       done;
        int         t;
    } exp_t;

    exp_t pixq[$];
    int   errq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   line_cnt = 0;
    logic chk_zero = 1'b0;
    logic final_chk = 1'b0;

    conv3x3_relu_stage #(.SHIFT(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_win_data    (win_data),
        .i_win_valid   (win_valid),
        .i_coef_we     (coef_we),
        .i_coef_addr   (coef_addr),
        .i_coef_data   (coef_data),
        .o_pixel       (o_pixel),
        .o_pixel_valid (o_pixel_valid),
        .o_line_done   (o_line_done),
        .o_coef_err    (o_coef_err),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor
    initial forever begin
        exp_t e;
        logic ee;
        @(negedge clk);
        if (o_pixel_valid) begin
            checks++;
            if (pixq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got pixel=%0d at t=%0d, nothing expected", o_pixel, cyc);
            end else begin
                e = pixq.pop_front();
                if (o_pixel !== e.pix || o_line_done !== e.done || cyc != e.t) begin
                    errors++;
                    $display("FAIL pixel: got pix=%0d done=%0b t=%0d, want pix=%0d done=%0b t=%0d",
                             o_pixel, o_line_done, cyc, e.pix, e.done, e.t);
                end
            end
        end else if (o_line_done) begin
            checks++;
            errors++;
            $display("FAIL done_no_valid: got line_done=1 without valid at t=%0d, want 0", cyc);
        end
        ee = (errq.size() > 0) && (errq[0] == cyc);
        if (ee) void'(errq.pop_front());
        if (ee || o_coef_err) begin
            checks++;
            if (o_coef_err !== ee) begin
                errors++;
                $display("FAIL coef_err: got %0b at t=%0d, want %0b", o_coef_err, cyc, ee);
            end
        end
        if (chk_zero) begin
            checks++;
            if ({o_pixel, o_pixel_valid, o_line_done, o_coef_err, o_busy} !== 12'h0) begin
                errors++;
                $display("FAIL reset_outputs: got pix=%0d v=%0b done=%0b err=%0b busy=%0b, want all 0",
                         o_pixel, o_pixel_valid, o_line_done, o_coef_err, o_busy);
            end
        end
        if (final_chk) begin
            checks++;
            if (pixq.size() != 0 || errq.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d pixels / %0d err pulses outstanding, want 0 / 0",
                         pixq.size(), errq.size());
            end
        end
    end

    function automatic logic [71:0] win1(input int k, input logic [7:0] v);
        logic [71:0] r;
        r = '0;
        r[8*k +: 8] = v;
        return r;
    endfunction

    function automatic logic [71:0] win_all(input logic [7:0] v);
        return {9{v}};
    endfunction

    task automatic cyc1(input logic v, input logic [71:0] d, input logic [7:0] ep,
                        input logic we, input logic [3:0] a, input logic [15:0] wd,
                        input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        win_valid = v;
        win_data  = d;
        coef_we   = we;
        coef_addr = a;
        coef_data = wd;
        if (v) begin
            e.pix  = ep;
            e.done = (line_cnt == OUT_W-1);
            e.t    = cyc + 4;
            pixq.push_back(e);
            line_cnt = (line_cnt == OUT_W-1) ? 0 : line_cnt + 1;
        end
        if (we && eerr) errq.push_back(cyc + 1);
    endtask

    task automatic idle();
        cyc1(1'b0, '0, 8'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic win(input logic [71:0] d, input logic [7:0] ep);
        cyc1(1'b1, d, ep, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] wd, input logic eerr);
        cyc1(1'b0, '0, 8'd0, 1'b1, a, wd, eerr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        coef_we   = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        chk_zero = 1'b1;
        @(posedge clk);
        #1;
        chk_zero = 1'b0;
        rst_n    = 1'b1;
        line_cnt = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pixq.size() != 0; i++) idle();
        idle();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Identity-like kernel, reserved address write, 4-cycle latency
        do_reset();
        wr(4'd12, 16'h1234, 1'b1);
        wr(4'd4, 16'd16, 1'b0);
        win(win1(4, 8'd200), 8'd200);
        drain();

        // All ones: 9*255 = 2295 >> 4 = 143
        do_reset();
        for (int k = 0; k < 9; k++) wr(4'(k), 16'd1, 1'b0);
        win(win_all(8'd255), 8'd143);
        drain();

        // w0 = -128: ReLU clamps to 0; bias 32767 gives 127>>4=7 and 32767>>4=2047 -> 255
        do_reset();
        wr(4'd0, 16'h0080, 1'b0);
        win(win1(0, 8'd255), 8'd0);
        win(win_all(8'd255), 8'd0);
        drain();
        do_reset();
        wr(4'd0, 16'h0080, 1'b0);
        wr(4'd9, 16'h7FFF, 1'b0);
        win(win1(0, 8'd255), 8'd7);
        win(win_all(8'd0), 8'd255);
        drain();

        // Window and write in the same idle cycle: write rejected, old bias kept
        do_reset();
        wr(4'd9, 16'h7FFF, 1'b0);
        cyc1(1'b1, win_all(8'd0), 8'd255, 1'b1, 4'd9, 16'h0000, 1'b1);
        win(win_all(8'd0), 8'd255);
        drain();

        // Saturation boundaries: (16*p + 15) >> 4
        do_reset();
        wr(4'd4, 16'd16, 1'b0);
        wr(4'd9, 16'd15, 1'b0);
        win(win1(4, 8'd255), 8'd255);
        win(win1(4, 8'd0), 8'd0);
        win(win1(4, 8'd240), 8'd240);
        drain();

        // Two lines: first with random gaps, second back-to-back with a mid-line write
        do_reset();
        wr(4'd4, 16'd16, 1'b0);
        for (int i = 0; i < OUT_W; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            win(win1(4, 8'(i)), 8'(i));
        end
        for (int i = 0; i < OUT_W; i++) begin
            if (i == 100)
                cyc1(1'b1, win1(4, 8'(i * 3)), 8'(i * 3), 1'b1, 4'd4, 16'd1, 1'b1);
            else
                win(win1(4, 8'(i * 3)), 8'(i * 3));
        end
        drain();

        // Reset with three windows in flight: they are dropped and coefficients clear
        do_reset();
        wr(4'd4, 16'd16, 1'b0);
        wr(4'd9, 16'd100, 1'b0);
        win(win1(4, 8'd10), 8'd0);
        win(win1(4, 8'd20), 8'd0);
        win(win1(4, 8'd30), 8'd0);
        pixq.delete();
        do_reset();
        repeat (8) idle();
        win(win_all(8'd255), 8'd0);
        drain();

        @(posedge clk);
        #1;
        final_chk = 1'b1;
        @(posedge clk);
        #1;
        final_chk = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
